// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types and helpers for the digit-serial add/subtract unit
package addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBC = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int MAX_BITS = 64;

    // Most positive value for a non-negative operand, most negative otherwise,
    // in the low `width` bits.
    function automatic logic [MAX_BITS-1:0] sat_word(input int width, input logic neg);
        logic [MAX_BITS-1:0] w;
        w = '0;
        for (int i = 0; i < MAX_BITS; i++) begin
            if (i < width - 1)
                w[i] = ~neg;
            else if (i == width - 1)
                w[i] = neg;
        end
        return w;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// rtl/addsub_slice.sv - combinational SLICE-bit ripple adder with optional b inversion
module addsub_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    input  logic             inv_b,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [SLICE-1:0] bb;
    logic [SLICE:0]   cc;

    always_comb begin
        bb    = b ^ {SLICE{inv_b}};
        cc    = '0;
        sum   = '0;
        cc[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            sum[i]  = a[i] ^ bb[i] ^ cc[i];
            cc[i+1] = (a[i] & bb[i]) | (cc[i] & (a[i] ^ bb[i]));
        end
        cout  = cc[SLICE];
        c_msb = cc[SLICE-1];
    end

endmodule

// File: rtl/addsub_serial.sv
// rtl/addsub_serial.sv - digit-serial add/subtract with carry chaining, saturation and condition codes
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int nBITS = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [nBITS-1:0] x,
    input  logic [nBITS-1:0] y,
    input  logic [1:0]       op,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [nBITS-1:0] result,
    output logic             ccn,
    output logic             ccz,
    output logic             ccv,
    output logic             ccc
);

    localparam int NSLICE = nBITS / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t            state, state_nx;
    logic [CW-1:0]     k;
    logic [nBITS-1:0]  xr, yr, acc, raw_full, res_final, sat_val;
    logic              inv_r, sat_r, carry;
    logic [SLICE-1:0]  s_sum;
    logic              s_cout, s_cmsb, last, accept, v_raw;

    assign accept = in_valid && (state == IDLE);
    assign last   = (k == CW'(NSLICE - 1));

    addsub_slice #(.SLICE(SLICE)) u_slice (
        .a     (xr[int'(k)*SLICE +: SLICE]),
        .b     (yr[int'(k)*SLICE +: SLICE]),
        .cin   (carry),
        .inv_b (inv_r),
        .sum   (s_sum),
        .cout  (s_cout),
        .c_msb (s_cmsb)
    );

    // Result as it stands once the current slice is merged in; only the
    // last-slice value is ever committed to result.
    always_comb begin
        raw_full = acc;
        raw_full[int'(k)*SLICE +: SLICE] = s_sum;
        sat_val   = nBITS'(sat_word(nBITS, xr[nBITS-1]));
        v_raw     = s_cmsb ^ s_cout;
        res_final = (sat_r && v_raw) ? sat_val : raw_full;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xr     <= '0;
            yr     <= '0;
            acc    <= '0;
            inv_r  <= 1'b0;
            sat_r  <= 1'b0;
            carry  <= 1'b0;
            k      <= '0;
            result <= '0;
            ccn    <= 1'b0;
            ccz    <= 1'b0;
            ccv    <= 1'b0;
            ccc    <= 1'b0;
        end else if (accept) begin
            xr    <= x;
            yr    <= y;
            sat_r <= sat;
            acc   <= '0;
            k     <= '0;
            case (op_t'(op))
                OP_ADD:  begin carry <= 1'b0; inv_r <= 1'b0; end
                OP_SUB:  begin carry <= 1'b1; inv_r <= 1'b1; end
                OP_ADC:  begin carry <= ccc;  inv_r <= 1'b0; end
                default: begin carry <= ccc;  inv_r <= 1'b1; end
            endcase
        end else if (state == RUN) begin
            acc[int'(k)*SLICE +: SLICE] <= s_sum;
            carry <= s_cout;
            k     <= k + 1'b1;
            if (last) begin
                result <= res_final;
                ccn    <= res_final[nBITS-1];
                ccz    <= (res_final == '0);
                ccv    <= v_raw;
                ccc    <= s_cout;
            end
        end
    end

endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
- Parametrised, digit-serial add/subtract unit with registered condition codes (N, Z, V, C).
- Processes nBITS-wide operands SLICE bits per clock through a single slice adder.
- Adds carry-chained multi-precision ops (ADC/SBC), optional signed saturation and valid/ready handshakes on both sides.
- Sits between the operand register file and the writeback/flags stage of the datapath.

Parameters:
- nBITS, 16: operand/result width; must be a multiple of SLICE.
- SLICE, 4: bits processed per cycle; NSLICE = nBITS/SLICE, must be >= 1.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  unit can accept operands.
- x  input  nBITS  operand A.
- y  input  nBITS  operand B.
- op  input  2  00 ADD, 01 SUB, 10 ADC, 11 SBC.
- sat  input  1  1 = saturate on signed overflow.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  nBITS  final result.
- ccn, ccz, ccv, ccc  output  1 each  condition codes for the last completed op.

Behaviour:
- Interface decision: one clock, clk. Reset is asynchronous and active-low, reset_n.
- Reset values:
  - state = IDLE; in_ready = 1, out_valid = 0.
  - result = 0; ccn, ccz, ccv, ccc = 0.
  - Stored carry flag = 0, slice counter = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture x, y, op, sat.
  - Carry-in: ADD = 0, SUB = 1, ADC = ccc, SBC = ccc. C = 1 means no borrow.
  - y is inverted for SUB/SBC.
  - Clear counter; go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle, add slice k (bits k*SLICE+SLICE-1 .. k*SLICE) with the running carry.
  - Write the slice into the partial result and store carry-out.
  - At k = NSLICE-1: also capture the carry into the MSB, then go to DONE.
- Latency: out_valid rises exactly NSLICE cycles after the accepting edge.
- Arithmetic rules (modulo 2^nBITS):
  - C = carry out of the MSB.
  - V = carry into MSB XOR carry out of MSB.
  - Saturation, when sat = 1 and V = 1: result = 0x7F..F if captured x MSB = 0, else 0x80..0.
  - N = result MSB after saturation.
  - Z = (result == 0) after saturation.
  - V and C always reflect the raw, unsaturated arithmetic.
- Flag timing: ccn, ccz, ccv, ccc and result update on the edge entering DONE, and only then.
- DONE:
  - out_valid = 1, in_ready = 0.
  - result and flags hold stable while out_ready = 0.
  - On out_ready: go to IDLE.
  - result and flags persist after leaving DONE; ccc feeds the next ADC/SBC.
- Throughput: one op per NSLICE+2 cycles minimum. No overlap of accept and deliver.
- Unknown op codes cannot occur (2-bit, fully decoded).
- in_valid or operand changes outside IDLE are ignored.
- Reset mid-operation: immediate abort to reset values. The partial result is discarded and the stored carry is cleared.
- NSLICE = 1: RUN lasts one cycle. Behaviour is otherwise identical.

Decomposition:
- Package addsub_pkg:
  - op_t enum (OP_ADD, OP_SUB, OP_ADC, OP_SBC).
  - state_t enum (IDLE, RUN, DONE).
  - Helper function computing the saturation value for a given width and sign.
- Sub-module addsub_slice: combinational SLICE-bit ripple adder.
  - Inputs: a, b, cin, inv_b.
  - Outputs: sum, cout, c_msb (carry into the top bit, used for V).
  - One instance, time-multiplexed by the counter.

Test Plan (nBITS = 16, SLICE = 4):
- ADD 0x7FFF + 0x0001, sat = 0 -> result 0x8000, N1 Z0 V1 C0. out_valid exactly 4 cycles after accept.
- Same operands, sat = 1 -> result 0x7FFF, N0 Z0 V1 C0. SUB 0x8000 - 0x0001, sat = 1 -> 0x8000, V1 C1.
- SUB 0x0005 - 0x0005 -> 0x0000, N0 Z1 V0 C1. SUB 0x0003 - 0x0005 -> 0xFFFE, N1 Z0 V0 C0.
- Chaining:
  - ADD 0xFFFF + 0x0001 -> 0x0000, C1 Z1.
  - Then ADC 0x0000 + 0x0000 -> 0x0001, C0 Z0.
  - Then SBC 0x0001 - 0x0000 with C0 -> 0x0000, C1 Z1.
- Backpressure: hold out_ready = 0 for 3 cycles in DONE -> result and flags stable, in_ready = 0, in_valid ignored. Raise out_ready -> IDLE next cycle, in_ready = 1.
- Reset mid-RUN: assert reset_n = 0 after 2 slices of ADD 0xFFFF + 0x0001 -> immediately out_valid 0, in_ready 1, flags 0. A following ADC 0x0001 + 0x0001 -> 0x0002, using C = 0.
